axi_interconnect_reqaddr_arbiter: RTL and testbench



---
 rtl/axi_interconnect_defs.sv | 34 +++
 rtl/axi_interconnect_rr_pick.sv | 33 +++
 rtl/axi_interconnect_reqaddr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_axi_interconnect_reqaddr_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_interconnect_defs.sv
// Shared definitions for the AXI interconnect request-address path:
// burst encodings, channel field widths, arbiter state and a CLOG2 helper.
package axi_interconnect_defs;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int QOS_W   = 4;
  localparam int CNT_W   = 8;

  // Index width for a port count; never narrower than one bit.
  function automatic int CLOG2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < value) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axi_interconnect_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr
// upward, wrapping modulo NUM_SLV. Shared with the W-data router.
module axi_interconnect_rr_pick #(
  parameter int NUM_SLV = 4,
  parameter int W_SEL   = 2
) (
  input  logic [NUM_SLV-1:0] req,
  input  logic [W_SEL-1:0]   ptr,
  output logic [NUM_SLV-1:0] gnt_onehot,
  output logic [W_SEL-1:0]   gnt_idx,
  output logic               any
);

  logic [W_SEL:0] idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      // One extra bit holds ptr+k before the explicit modulo wrap.
      idx = {1'b0, ptr} + (W_SEL+1)'(k);
      if (idx >= (W_SEL+1)'(NUM_SLV)) idx = idx - (W_SEL+1)'(NUM_SLV);
      if (!any && req[idx[W_SEL-1:0]]) begin
        any                           = 1'b1;
        gnt_idx                       = idx[W_SEL-1:0];
        gnt_onehot[idx[W_SEL-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_interconnect_reqaddr_arbiter.sv
// Round-robin AR/AW arbiter with registered output slice and outstanding-burst
// limiter. Define AXI_ICN_ARB_QOS_EN to restrict arbitration to highest-QoS ports.
module axi_interconnect_reqaddr_arbiter
  import axi_interconnect_defs::*;
#(
  parameter int NUM_SLV     = 4,
  parameter int WIDTH_ID    = 4,
  parameter int WIDTH_ADDR  = 32,
  parameter int WIDTH_AUSER = 1,
  parameter int MAX_OUTSTD  = 8,
  parameter int W_SEL       = CLOG2(NUM_SLV)
) (
  input  logic                            clk_sys,
  input  logic                            rst_n,
  input  logic [NUM_SLV*WIDTH_ID-1:0]     s_reqaid,
  input  logic [NUM_SLV*WIDTH_ADDR-1:0]   s_reqaaddr,
  input  logic [NUM_SLV*LEN_W-1:0]        s_reqalen,
  input  logic [NUM_SLV*SIZE_W-1:0]       s_reqasize,
  input  logic [NUM_SLV*BURST_W-1:0]      s_reqaburst,
  input  logic [NUM_SLV*CACHE_W-1:0]      s_reqacache,
  input  logic [NUM_SLV*PROT_W-1:0]       s_reqaprot,
  input  logic [NUM_SLV*QOS_W-1:0]        s_reqaqos,
  input  logic [NUM_SLV*WIDTH_AUSER-1:0]  s_reqauser,
  input  logic [NUM_SLV-1:0]              s_reqavalid,
  output logic [NUM_SLV-1:0]              s_reqaready,
  output logic [WIDTH_ID-1:0]             m_reqaid,
  output logic [WIDTH_ADDR-1:0]           m_reqaaddr,
  output logic [LEN_W-1:0]                m_reqalen,
  output logic [SIZE_W-1:0]              m_reqasize,
  output logic [BURST_W-1:0]              m_reqaburst,
  output logic [CACHE_W-1:0]              m_reqacache,
  output logic [PROT_W-1:0]               m_reqaprot,
  output logic [QOS_W-1:0]                m_reqaqos,
  output logic [WIDTH_AUSER-1:0]          m_reqauser,
  output logic                            m_reqavalid,
  input  logic                            m_reqaready,
  output logic                            grant_en,
  output logic [W_SEL-1:0]                grant_idx,
  output logic [LEN_W-1:0]                grant_len,
  input  logic                            cmpl_en,
  output logic [CNT_W-1:0]                outstd_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTD);
  localparam logic [W_SEL-1:0] LAST_IDX = W_SEL'(NUM_SLV - 1);

  logic [WIDTH_ID-1:0]    id_a    [NUM_SLV];
  logic [WIDTH_ADDR-1:0]  addr_a  [NUM_SLV];
  logic [LEN_W-1:0]       len_a   [NUM_SLV];
  logic [SIZE_W-1:0]      size_a  [NUM_SLV];
  logic [BURST_W-1:0]     burst_a [NUM_SLV];
  logic [CACHE_W-1:0]     cache_a [NUM_SLV];
  logic [PROT_W-1:0]      prot_a  [NUM_SLV];
  logic [QOS_W-1:0]       qos_a   [NUM_SLV];
  logic [WIDTH_AUSER-1:0] user_a  [NUM_SLV];

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slice
    assign id_a[gi]    = s_reqaid[gi*WIDTH_ID +: WIDTH_ID];
    assign addr_a[gi]  = s_reqaaddr[gi*WIDTH_ADDR +: WIDTH_ADDR];
    assign len_a[gi]   = s_reqalen[gi*LEN_W +: LEN_W];
    assign size_a[gi]  = s_reqasize[gi*SIZE_W +: SIZE_W];
    assign burst_a[gi] = s_reqaburst[gi*BURST_W +: BURST_W];
    assign cache_a[gi] = s_reqacache[gi*CACHE_W +: CACHE_W];
    assign prot_a[gi]  = s_reqaprot[gi*PROT_W +: PROT_W];
    assign qos_a[gi]   = s_reqaqos[gi*QOS_W +: QOS_W];
    assign user_a[gi]  = s_reqauser[gi*WIDTH_AUSER +: WIDTH_AUSER];
  end

  logic [NUM_SLV-1:0] eligible;
  logic [NUM_SLV-1:0] win_onehot;
  logic [W_SEL-1:0]   win_idx;
  logic               win_any;
  logic               load;

`ifdef AXI_ICN_ARB_QOS_EN
  logic [QOS_W-1:0] qos_max;

  always_comb begin
    qos_max = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (s_reqavalid[i] && (qos_a[i] > qos_max)) qos_max = qos_a[i];
    end
  end

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_elig
    assign eligible[gi] = s_reqavalid[gi] & (qos_a[gi] == qos_max);
  end
`else
  assign eligible = s_reqavalid;
`endif

  logic [W_SEL-1:0] rr_ptr_q;

  axi_interconnect_rr_pick #(
    .NUM_SLV (NUM_SLV),
    .W_SEL   (W_SEL)
  ) u_rr_pick (
    .req        (eligible),
    .ptr        (rr_ptr_q),
    .gnt_onehot (win_onehot),
    .gnt_idx    (win_idx),
    .any        (win_any)
  );

  arb_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH_ID-1:0]    id_q;
  logic [WIDTH_ADDR-1:0]  addr_q;
  logic [LEN_W-1:0]       len_q;
  logic [SIZE_W-1:0]      size_q;
  logic [BURST_W-1:0]     burst_q;
  logic [CACHE_W-1:0]     cache_q;
  logic [PROT_W-1:0]      prot_q;
  logic [QOS_W-1:0]       qos_q;
  logic [WIDTH_AUSER-1:0] user_q;
  logic [W_SEL-1:0]       idx_q;

  // A completion in the same cycle frees the slot the new burst takes.
  assign load = (~m_reqavalid | m_reqaready) & ((cnt_q < MAX_CNT) | cmpl_en) & win_any;
  assign s_reqaready = load ? win_onehot : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (load && !cmpl_en) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!load && cmpl_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      cache_q  <= '0;
      prot_q   <= '0;
      qos_q    <= '0;
      user_q   <= '0;
      idx_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        ST_EMPTY: if (load) state_q <= ST_FULL;
        ST_FULL:  if (m_reqaready && !load) state_q <= ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
      if (load) begin
        id_q     <= id_a[win_idx];
        addr_q   <= addr_a[win_idx];
        len_q    <= len_a[win_idx];
        size_q   <= size_a[win_idx];
        burst_q  <= burst_a[win_idx];
        cache_q  <= cache_a[win_idx];
        prot_q   <= prot_a[win_idx];
        qos_q    <= qos_a[win_idx];
        user_q   <= user_a[win_idx];
        idx_q    <= win_idx;
        rr_ptr_q <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // A completion with nothing outstanding means the downstream accounting is broken.
  always_ff @(posedge clk_sys) begin
    if (rst_n) assert (!(cmpl_en && !load && (cnt_q == '0)));
  end
`endif

  assign m_reqavalid = (state_q == ST_FULL);
  assign m_reqaid    = id_q;
  assign m_reqaaddr  = addr_q;
  assign m_reqalen   = len_q;
  assign m_reqasize  = size_q;
  assign m_reqaburst = burst_q;
  assign m_reqacache = cache_q;
  assign m_reqaprot  = prot_q;
  assign m_reqaqos   = qos_q;
  assign m_reqauser  = user_q;
  assign grant_idx   = idx_q;
  assign grant_len   = len_q;
  assign grant_en    = m_reqavalid & m_reqaready;
  assign outstd_cnt  = cnt_q;

endmodule

// File: tb/tb_axi_interconnect_reqaddr_arbiter.sv
// Directed plus randomized bench for the request-address arbiter; a
// transaction-level model predicts grants, held fields and outstanding count.
`timescale 1ns/1ps
module tb_axi_interconnect_reqaddr_arbiter;

  localparam int NUM_SLV     = 4;
  localparam int WIDTH_ID    = 4;
  localparam int WIDTH_ADDR  = 32;
  localparam int WIDTH_AUSER = 1;
  localparam int MAX_OUTSTD  = 3;
  localparam int W_SEL       = 2;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [0:0]  user;
  } req_t;

  req_t slv [NUM_SLV];

  logic [NUM_SLV*WIDTH_ID-1:0]    s_reqaid;
  logic [NUM_SLV*WIDTH_ADDR-1:0]  s_reqaaddr;
  logic [NUM_SLV*8-1:0]           s_reqalen;
  logic [NUM_SLV*3-1:0]           s_reqasize;
  logic [NUM_SLV*2-1:0]           s_reqaburst;
  logic [NUM_SLV*4-1:0]           s_reqacache;
  logic [NUM_SLV*3-1:0]           s_reqaprot;
  logic [NUM_SLV*4-1:0]           s_reqaqos;
  logic [NUM_SLV*WIDTH_AUSER-1:0] s_reqauser;
  logic [NUM_SLV-1:0]             s_reqavalid = '0;
  logic [NUM_SLV-1:0]             s_reqaready;
  logic [WIDTH_ID-1:0]            m_reqaid;
  logic [WIDTH_ADDR-1:0]          m_reqaaddr;
  logic [7:0]                     m_reqalen;
  logic [2:0]                     m_reqasize;
  logic [1:0]                     m_reqaburst;
  logic [3:0]                     m_reqacache;
  logic [2:0]                     m_reqaprot;
  logic [3:0]                     m_reqaqos;
  logic [WIDTH_AUSER-1:0]         m_reqauser;
  logic                           m_reqavalid;
  logic                           m_reqaready = 1'b0;
  logic                           grant_en;
  logic [W_SEL-1:0]               grant_idx;
  logic [7:0]                     grant_len;
  logic                           cmpl_en = 1'b0;
  logic [7:0]                     outstd_cnt;

  always_comb begin
    s_reqaid = '0; s_reqaaddr = '0; s_reqalen = '0; s_reqasize = '0; s_reqaburst = '0;
    s_reqacache = '0; s_reqaprot = '0; s_reqaqos = '0; s_reqauser = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      s_reqaid[i*4 +: 4]     = slv[i].id;
      s_reqaaddr[i*32 +: 32] = slv[i].addr;
      s_reqalen[i*8 +: 8]    = slv[i].len;
      s_reqasize[i*3 +: 3]   = slv[i].size;
      s_reqaburst[i*2 +: 2]  = slv[i].burst;
      s_reqacache[i*4 +: 4]  = slv[i].cache;
      s_reqaprot[i*3 +: 3]   = slv[i].prot;
      s_reqaqos[i*4 +: 4]    = slv[i].qos;
      s_reqauser[i +: 1]     = slv[i].user;
    end
  end

  axi_interconnect_reqaddr_arbiter #(
    .NUM_SLV     (NUM_SLV),
    .WIDTH_ID    (WIDTH_ID),
    .WIDTH_ADDR  (WIDTH_ADDR),
    .WIDTH_AUSER (WIDTH_AUSER),
    .MAX_OUTSTD  (MAX_OUTSTD),
    .W_SEL       (W_SEL)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .s_reqaid    (s_reqaid),
    .s_reqaaddr  (s_reqaaddr),
    .s_reqalen   (s_reqalen),
    .s_reqasize  (s_reqasize),
    .s_reqaburst (s_reqaburst),
    .s_reqacache (s_reqacache),
    .s_reqaprot  (s_reqaprot),
    .s_reqaqos   (s_reqaqos),
    .s_reqauser  (s_reqauser),
    .s_reqavalid (s_reqavalid),
    .s_reqaready (s_reqaready),
    .m_reqaid    (m_reqaid),
    .m_reqaaddr  (m_reqaaddr),
    .m_reqalen   (m_reqalen),
    .m_reqasize  (m_reqasize),
    .m_reqaburst (m_reqaburst),
    .m_reqacache (m_reqacache),
    .m_reqaprot  (m_reqaprot),
    .m_reqaqos   (m_reqaqos),
    .m_reqauser  (m_reqauser),
    .m_reqavalid (m_reqavalid),
    .m_reqaready (m_reqaready),
    .grant_en    (grant_en),
    .grant_idx   (grant_idx),
    .grant_len   (grant_len),
    .cmpl_en     (cmpl_en),
    .outstd_cnt  (outstd_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: pending master request, round-robin start, outstanding bursts.
  bit   mod_v   = 1'b0;
  req_t mod_req;
  int   mod_idx = 0;
  int   mod_rr  = 0;
  int   mod_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_fields(input bit rand_qos);
    for (int i = 0; i < NUM_SLV; i++) begin
      slv[i].id    = 4'($urandom);
      slv[i].addr  = $urandom;
      slv[i].len   = 8'($urandom);
      slv[i].size  = 3'($urandom);
      slv[i].burst = 2'($urandom_range(0, 2));
      slv[i].cache = 4'($urandom);
      slv[i].prot  = 3'($urandom);
      slv[i].qos   = rand_qos ? 4'($urandom) : 4'd0;
      slv[i].user  = 1'($urandom);
    end
  endtask

  // Winner: first eligible port counting up from the round-robin start, modulo NUM_SLV.
  task automatic pick(output int w, output bit any);
    bit elig [NUM_SLV];
    int qmax;
    int p;
    qmax = 0;
    w    = 0;
    any  = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (s_reqavalid[i] && int'(slv[i].qos) > qmax) qmax = int'(slv[i].qos);
    end
    for (int i = 0; i < NUM_SLV; i++) begin
`ifdef AXI_ICN_ARB_QOS_EN
      elig[i] = s_reqavalid[i] && (int'(slv[i].qos) == qmax);
`else
      elig[i] = s_reqavalid[i];
`endif
    end
    for (int k = 0; k < NUM_SLV; k++) begin
      p = (mod_rr + k) % NUM_SLV;
      if (!any && elig[p]) begin
        any = 1'b1;
        w   = p;
      end
    end
  endtask

  // Called at a falling edge with inputs set; checks, advances one clock, returns at the next falling edge.
  task automatic tick();
    int w;
    bit any;
    bit ld;
    #2;
    pick(w, any);
    ld = (!mod_v || m_reqaready) && ((mod_cnt < MAX_OUTSTD) || cmpl_en) && any;
    chk("s_reqaready", 64'(s_reqaready), ld ? (64'd1 << w) : 64'd0);
    chk("grant_en", 64'(grant_en), 64'(mod_v && m_reqaready));
    chk("m_reqavalid", 64'(m_reqavalid), 64'(mod_v));
    chk("outstd_cnt", 64'(outstd_cnt), 64'(mod_cnt));
    if (mod_v) begin
      chk("m_reqaid", 64'(m_reqaid), 64'(mod_req.id));
      chk("m_reqaaddr", 64'(m_reqaaddr), 64'(mod_req.addr));
      chk("m_reqalen", 64'(m_reqalen), 64'(mod_req.len));
      chk("m_reqasize", 64'(m_reqasize), 64'(mod_req.size));
      chk("m_reqaburst", 64'(m_reqaburst), 64'(mod_req.burst));
      chk("m_reqacache", 64'(m_reqacache), 64'(mod_req.cache));
      chk("m_reqaprot", 64'(m_reqaprot), 64'(mod_req.prot));
      chk("m_reqaqos", 64'(m_reqaqos), 64'(mod_req.qos));
      chk("m_reqauser", 64'(m_reqauser), 64'(mod_req.user));
      chk("grant_idx", 64'(grant_idx), 64'(mod_idx));
      chk("grant_len", 64'(grant_len), 64'(mod_req.len));
      if (m_reqaready) begin
        $display("handshake port=%0d addr=%08h len=%0d outstd=%0d", grant_idx, m_reqaaddr, grant_len, outstd_cnt);
      end
    end
    @(posedge clk_sys);
    if (ld) begin
      mod_req = slv[w];
      mod_idx = w;
      mod_v   = 1'b1;
      mod_rr  = (w + 1) % NUM_SLV;
    end else if (mod_v && m_reqaready) begin
      mod_v = 1'b0;
    end
    if (ld && !cmpl_en) mod_cnt++;
    else if (!ld && cmpl_en && mod_cnt > 0) mod_cnt--;
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    s_reqavalid = '0;
    m_reqaready = 1'b0;
    cmpl_en     = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("rst_m_reqavalid", 64'(m_reqavalid), 64'd0);
    chk("rst_outstd_cnt", 64'(outstd_cnt), 64'd0);
    chk("rst_s_reqaready", 64'(s_reqaready), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_m_reqaaddr", 64'(m_reqaaddr), 64'd0);
    chk("rst_grant_len", 64'(grant_len), 64'd0);
    rst_n   = 1'b1;
    mod_v   = 1'b0;
    mod_rr  = 0;
    mod_cnt = 0;
    @(negedge clk_sys);
  endtask

  initial begin
    rand_fields(1'b0);
    mod_req = slv[0];
    do_reset();

    // Single request from port 2.
    rand_fields(1'b0);
    slv[2].addr = 32'h0000_1000;
    slv[2].len  = 8'd3;
    s_reqavalid = 4'b0100;
    m_reqaready = 1'b1;
    tick();
    s_reqavalid = '0;
    #1;
    chk("single_addr", 64'(m_reqaaddr), 64'h1000);
    chk("single_idx", 64'(grant_idx), 64'd2);
    chk("single_len", 64'(grant_len), 64'd3);
    chk("single_grant_en", 64'(grant_en), 64'd1);
    chk("single_cnt", 64'(outstd_cnt), 64'd1);
    tick();
    cmpl_en = 1'b1;
    tick();
    cmpl_en = 1'b0;

    // All ports requesting continuously: grants rotate 0,1,2,3 with no idle cycle.
    do_reset();
    s_reqavalid = '1;
    m_reqaready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rand_fields(1'b0);
      cmpl_en = (mod_cnt > 0);
      if (k > 0) begin
        #1;
        chk("rr_order", 64'(grant_idx), 64'((k - 1) % NUM_SLV));
        chk("rr_no_idle", 64'(grant_en), 64'd1);
      end
      tick();
    end

    // Master stall with two ports requesting.
    s_reqavalid = 4'b1010;
    m_reqaready = 1'b0;
    cmpl_en     = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_fields(1'b0);
      #1;
      chk("stall_ready", 64'(s_reqaready), 64'd0);
      chk("stall_valid", 64'(m_reqavalid), 64'd1);
      tick();
    end
    m_reqaready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cmpl_en = (mod_cnt > 0);
      tick();
    end

    // Outstanding limit: fourth request blocks until a completion arrives.
    do_reset();
    s_reqavalid = 4'b0001;
    m_reqaready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_fields(1'b0);
      tick();
    end
    #1;
    chk("lim_block_ready", 64'(s_reqaready), 64'd0);
    chk("lim_cnt_full", 64'(outstd_cnt), 64'(MAX_OUTSTD));
    tick();
    cmpl_en = 1'b1;
    #1;
    chk("lim_accept_ready", 64'(s_reqaready), 64'd1);
    tick();
    cmpl_en = 1'b0;
    #1;
    chk("lim_cnt_hold", 64'(outstd_cnt), 64'(MAX_OUTSTD));
    chk("lim_valid", 64'(m_reqavalid), 64'd1);

    // Asynchronous reset while a request is pending and the count is at its limit.
    m_reqaready = 1'b0;
    s_reqavalid = '0;
    rst_n       = 1'b0;
    #1;
    chk("arst_m_reqavalid", 64'(m_reqavalid), 64'd0);
    chk("arst_outstd_cnt", 64'(outstd_cnt), 64'd0);
    chk("arst_m_reqaaddr", 64'(m_reqaaddr), 64'd0);
    chk("arst_grant_len", 64'(grant_len), 64'd0);
    mod_v   = 1'b0;
    mod_rr  = 0;
    mod_cnt = 0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    s_reqavalid = '1;
    m_reqaready = 1'b1;
    tick();
    #1;
    chk("restart_idx", 64'(grant_idx), 64'd0);
    s_reqavalid = '0;
    cmpl_en     = 1'b1;
    tick();
    cmpl_en = 1'b0;

`ifdef AXI_ICN_ARB_QOS_EN
    // Higher QoS wins regardless of round-robin position.
    do_reset();
    rand_fields(1'b0);
    slv[1].qos  = 4'd4;
    slv[3].qos  = 4'd9;
    s_reqavalid = 4'b1010;
    m_reqaready = 1'b1;
    tick();
    s_reqavalid = 4'b0010;
    #1;
    chk("qos_first", 64'(grant_idx), 64'd3);
    tick();
    s_reqavalid = '0;
    #1;
    chk("qos_second", 64'(grant_idx), 64'd1);
    tick();
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rand_fields(1'b1);
      s_reqavalid = 4'($urandom);
      m_reqaready = ($urandom_range(0, 3) != 0);
      cmpl_en     = (mod_cnt > 0) && ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
